// File: rtl/zx_mem_pkg.sv
// Shared definitions for the VRAM arbiter: bus widths, FSM state encoding
// and small state-classification helpers.
package zx_mem_pkg;

   localparam int VA_W   = 14;
   localparam int DATA_W = 8;

   typedef enum logic [2:0] {
      ARB_IDLE = 3'd0,
      ARB_V1   = 3'd1,
      ARB_V2   = 3'd2,
      ARB_C1   = 3'd3,
      ARB_C2   = 3'd4
   } arb_state_t;

   // True in the states where the VRAM bus is owned by the CPU.
   function automatic logic is_cpu_state(input arb_state_t s);
      return (s == ARB_C1) || (s == ARB_C2);
   endfunction

   // True in the states where the VRAM bus is owned by the video fetcher.
   function automatic logic is_video_state(input arb_state_t s);
      return (s == ARB_V1) || (s == ARB_V2);
   endfunction

endpackage

// File: rtl/arb_req_latch.sv
// Per-requester front end: holds one outstanding request (pending flag and
// captured payload) until the arbiter grants it. A request pulse arriving
// while one is already pending is dropped and flagged in the sticky overrun.
module arb_req_latch #(
   parameter int PAYLOAD_W = 14
) (
   input  logic                 clk14,
   input  logic                 rst_n,
   input  logic                 req,
   input  logic [PAYLOAD_W-1:0] payload,
   input  logic                 grant,
   output logic                 pending,
   output logic [PAYLOAD_W-1:0] cap,
   output logic                 overrun
);

   // Capture on an accepted request, release on grant, remember drops.
   always_ff @(posedge clk14) begin
      if (!rst_n) begin
         pending <= 1'b0;
         cap     <= '0;
         overrun <= 1'b0;
      end else begin
         if (req && !pending) begin
            pending <= 1'b1;
            cap     <= payload;
         end else if (grant) begin
            pending <= 1'b0;
         end
         if (req && pending) begin
            overrun <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/vram_arbiter.sv
// Two-port VRAM arbiter: a video fetcher and the CPU share one VRAM. Each
// access owns the bus for exactly two cycles; video has fixed priority, and
// grants are only taken at IDLE or at the end of an access.
module vram_arbiter
   import zx_mem_pkg::*;
(
   input  logic              clk14,
   input  logic              rst_n,
   input  logic              vreq,
   input  logic [VA_W-1:0]   vaddr,
   output logic [DATA_W-1:0] vdata,
   output logic              vvalid,
   input  logic              creq,
   input  logic              cwe,
   input  logic [VA_W-1:0]   caddr,
   input  logic [DATA_W-1:0] cdin,
   output logic [DATA_W-1:0] cdout,
   output logic              cack,
   output logic              cwait,
   output logic              voverrun,
   output logic [VA_W-1:0]   va,
   output logic [DATA_W-1:0] vramdin,
   input  logic [DATA_W-1:0] vramdout,
   output logic              vramcs,
   output logic              vramoe,
   output logic              vramwe
);

   localparam int C_PAY_W = VA_W + DATA_W + 1;

   arb_state_t         state;
   arb_state_t         state_nx;

   logic               v_pend;
   logic [VA_W-1:0]    v_cap;
   logic               v_grant;

   logic               c_pend;
   logic [C_PAY_W-1:0] c_cap;
   logic               c_grant;
   logic               c_overrun_unused;

   logic [VA_W-1:0]    c_cap_addr;
   logic [DATA_W-1:0]  c_cap_din;
   logic               c_cap_we;

   // Write flag of the CPU access currently on the bus.
   logic               cur_we;

   logic               cs_nx;
   logic               oe_nx;
   logic               we_nx;
   logic               cwait_nx;

   assign c_cap_addr = c_cap[VA_W-1:0];
   assign c_cap_din  = c_cap[VA_W +: DATA_W];
   assign c_cap_we   = c_cap[VA_W+DATA_W];

   arb_req_latch #(
      .PAYLOAD_W (VA_W)
   ) u_vid_latch (
      .clk14   (clk14),
      .rst_n   (rst_n),
      .req     (vreq),
      .payload (vaddr),
      .grant   (v_grant),
      .pending (v_pend),
      .cap     (v_cap),
      .overrun (voverrun)
   );

   arb_req_latch #(
      .PAYLOAD_W (C_PAY_W)
   ) u_cpu_latch (
      .clk14   (clk14),
      .rst_n   (rst_n),
      .req     (creq),
      .payload ({cwe, cdin, caddr}),
      .grant   (c_grant),
      .pending (c_pend),
      .cap     (c_cap),
      .overrun (c_overrun_unused)
   );

   // FSM state register.
   always_ff @(posedge clk14) begin
      if (!rst_n) begin
         state <= ARB_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next state, grants and next-cycle bus strobes; grants are taken from
   // the pending flags only, video first.
   always_comb begin
      state_nx = state;
      v_grant  = 1'b0;
      c_grant  = 1'b0;
      case (state)
         ARB_V1: state_nx = ARB_V2;
         ARB_C1: state_nx = ARB_C2;
         default: begin
            if (v_pend) begin
               state_nx = ARB_V1;
               v_grant  = 1'b1;
            end else if (c_pend) begin
               state_nx = ARB_C1;
               c_grant  = 1'b1;
            end else begin
               state_nx = ARB_IDLE;
            end
         end
      endcase

      cs_nx = (state_nx != ARB_IDLE);
      oe_nx = 1'b0;
      we_nx = 1'b0;
      case (state_nx)
         ARB_V1, ARB_V2: oe_nx = 1'b1;
         ARB_C1:         oe_nx = !c_cap_we;
         ARB_C2: begin
            oe_nx = !cur_we;
            we_nx = cur_we;
         end
         default: begin
            oe_nx = 1'b0;
            we_nx = 1'b0;
         end
      endcase

      // CPU is waiting while a request is arriving, pending, or on the bus.
      cwait_nx = creq || c_pend || is_cpu_state(state_nx);
   end

   // VRAM bus registers; address/data load at grant and hold otherwise.
   always_ff @(posedge clk14) begin
      if (!rst_n) begin
         va      <= '0;
         vramdin <= '0;
         vramcs  <= 1'b0;
         vramoe  <= 1'b0;
         vramwe  <= 1'b0;
         cur_we  <= 1'b0;
      end else begin
         vramcs <= cs_nx;
         vramoe <= oe_nx;
         vramwe <= we_nx;
         if (v_grant) begin
            va <= v_cap;
         end else if (c_grant) begin
            va      <= c_cap_addr;
            vramdin <= c_cap_din;
            cur_we  <= c_cap_we;
         end
      end
   end

   // Completion: latch read data and pulse the done strobes as an access ends.
   always_ff @(posedge clk14) begin
      if (!rst_n) begin
         vdata  <= '0;
         vvalid <= 1'b0;
         cdout  <= '0;
         cack   <= 1'b0;
         cwait  <= 1'b0;
      end else begin
         vvalid <= (state == ARB_V2);
         cack   <= (state == ARB_C2);
         cwait  <= cwait_nx;
         if (state == ARB_V2) begin
            vdata <= vramdout;
         end
         if ((state == ARB_C2) && !cur_we) begin
            cdout <= vramdout;
         end
      end
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios followed by random traffic, all
// compared every cycle against a transaction-level reference model.
module tb_vram_arbiter;

   logic        clk14 = 1'b0;
   logic        rst_n;
   logic        vreq;
   logic [13:0] vaddr;
   logic [7:0]  vdata;
   logic        vvalid;
   logic        creq;
   logic        cwe;
   logic [13:0] caddr;
   logic [7:0]  cdin;
   logic [7:0]  cdout;
   logic        cack;
   logic        cwait;
   logic        voverrun;
   logic [13:0] va;
   logic [7:0]  vramdin;
   logic [7:0]  vramdout;
   logic        vramcs;
   logic        vramoe;
   logic        vramwe;

   int checks = 0;
   int errors = 0;
   int vv_seen = 0;
   int ck_seen = 0;

   always #35 clk14 = ~clk14;

   vram_arbiter dut (
      .clk14    (clk14),
      .rst_n    (rst_n),
      .vreq     (vreq),
      .vaddr    (vaddr),
      .vdata    (vdata),
      .vvalid   (vvalid),
      .creq     (creq),
      .cwe      (cwe),
      .caddr    (caddr),
      .cdin     (cdin),
      .cdout    (cdout),
      .cack     (cack),
      .cwait    (cwait),
      .voverrun (voverrun),
      .va       (va),
      .vramdin  (vramdin),
      .vramdout (vramdout),
      .vramcs   (vramcs),
      .vramoe   (vramoe),
      .vramwe   (vramwe)
   );

   // VRAM device driven by the DUT, plus the bench's own copy of its contents.
   logic [7:0] mem     [0:16383];
   logic [7:0] ref_mem [0:16383];

   assign vramdout = mem[va];

   always @(posedge clk14) begin
      if (vramcs && vramwe) mem[va] <= vramdin;
   end

   // Reference model: pending requests, the access on the bus (owner plus
   // which of its two cycles), and the outputs that follow from them.
   logic        m_v_pend, m_c_pend, m_c_we;
   logic [13:0] m_v_addr, m_c_addr;
   logic [7:0]  m_c_din;
   int          m_owner;      // 0 none, 1 video, 2 cpu
   int          m_phase;      // 0 idle, 1 first cycle, 2 second cycle
   logic [13:0] m_cur_addr;
   logic [7:0]  m_cur_din;
   logic        m_cur_we;

   logic [7:0]  e_vdata, e_cdout, e_vramdin;
   logic [13:0] e_va;
   logic        e_vvalid, e_cack, e_cwait, e_voverrun, e_cs, e_oe, e_we;

   task automatic model_reset();
      m_v_pend = 0; m_c_pend = 0; m_c_we = 0;
      m_v_addr = '0; m_c_addr = '0; m_c_din = '0;
      m_owner = 0; m_phase = 0;
      m_cur_addr = '0; m_cur_din = '0; m_cur_we = 0;
      e_vdata = '0; e_cdout = '0; e_vramdin = '0; e_va = '0;
      e_vvalid = 0; e_cack = 0; e_cwait = 0; e_voverrun = 0;
      e_cs = 0; e_oe = 0; e_we = 0;
   endtask

   task automatic model_step();
      logic old_v, old_c;
      if (!rst_n) begin
         model_reset();
         return;
      end
      e_vvalid = 0;
      e_cack   = 0;
      if (m_phase == 2) begin
         if (m_owner == 1) begin
            e_vdata  = ref_mem[m_cur_addr];
            e_vvalid = 1;
         end else begin
            if (m_cur_we) ref_mem[m_cur_addr] = m_cur_din;
            else          e_cdout = ref_mem[m_cur_addr];
            e_cack = 1;
         end
      end
      old_v = m_v_pend;
      old_c = m_c_pend;
      if (m_phase == 1) begin
         m_phase = 2;
      end else if (old_v) begin
         m_owner = 1; m_phase = 1; m_cur_addr = m_v_addr; m_v_pend = 0;
      end else if (old_c) begin
         m_owner = 2; m_phase = 1; m_cur_addr = m_c_addr;
         m_cur_din = m_c_din; m_cur_we = m_c_we; m_c_pend = 0;
      end else begin
         m_owner = 0; m_phase = 0;
      end
      if (vreq) begin
         if (old_v) e_voverrun = 1;
         else begin m_v_pend = 1; m_v_addr = vaddr; end
      end
      if (creq && !old_c) begin
         m_c_pend = 1; m_c_addr = caddr; m_c_din = cdin; m_c_we = cwe;
      end
      if (m_phase != 0) begin
         e_cs = 1;
         e_va = m_cur_addr;
         if (m_owner == 1) begin
            e_oe = 1; e_we = 0;
         end else begin
            e_vramdin = m_cur_din;
            e_oe = !m_cur_we;
            e_we = m_cur_we && (m_phase == 2);
         end
      end else begin
         e_cs = 0; e_oe = 0; e_we = 0;
      end
      e_cwait = m_c_pend || (m_owner == 2 && m_phase != 0);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic compare_all();
      chk("vvalid",   {31'd0, vvalid},   {31'd0, e_vvalid});
      chk("vdata",    {24'd0, vdata},    {24'd0, e_vdata});
      chk("cack",     {31'd0, cack},     {31'd0, e_cack});
      chk("cdout",    {24'd0, cdout},    {24'd0, e_cdout});
      chk("cwait",    {31'd0, cwait},    {31'd0, e_cwait});
      chk("voverrun", {31'd0, voverrun}, {31'd0, e_voverrun});
      chk("vramcs",   {31'd0, vramcs},   {31'd0, e_cs});
      chk("vramoe",   {31'd0, vramoe},   {31'd0, e_oe});
      chk("vramwe",   {31'd0, vramwe},   {31'd0, e_we});
      chk("va",       {18'd0, va},       {18'd0, e_va});
      chk("vramdin",  {24'd0, vramdin},  {24'd0, e_vramdin});
   endtask

   // One clock: model advances on the edge, outputs compared half a cycle later.
   task automatic tick();
      @(posedge clk14);
      model_step();
      @(negedge clk14);
      compare_all();
      if (vvalid) vv_seen++;
      if (cack)   ck_seen++;
   endtask

   task automatic idle_inputs();
      vreq = 0; creq = 0; cwe = 0;
   endtask

   initial begin
      int vv0;
      int ck0;
      for (int i = 0; i < 16384; i++) begin
         mem[i]     = 8'((i * 13 + 7) ^ (i >> 8));
         ref_mem[i] = mem[i];
      end
      mem[14'h1800]     = 8'h5A;
      ref_mem[14'h1800] = 8'h5A;
      model_reset();
      rst_n = 0; vaddr = '0; caddr = '0; cdin = '0;
      idle_inputs();
      @(negedge clk14);
      tick();
      tick();
      chk("reset_cs", {31'd0, vramcs}, 32'd0);
      chk("reset_cwait", {31'd0, cwait}, 32'd0);
      rst_n = 1;
      tick();

      // Single video read of 0x1800.
      vreq = 1; vaddr = 14'h1800;
      tick();
      idle_inputs();
      tick();
      chk("v_read_va_c1", {18'd0, va}, 32'h1800);
      tick();
      chk("v_read_oe_c2", {31'd0, vramoe}, 32'd1);
      tick();
      chk("v_read_vvalid", {31'd0, vvalid}, 32'd1);
      chk("v_read_vdata", {24'd0, vdata}, 32'h5A);
      tick();
      chk("v_read_hold", {24'd0, vdata}, 32'h5A);

      // CPU write 0xC3 to 0x0100.
      creq = 1; cwe = 1; caddr = 14'h0100; cdin = 8'hC3;
      tick();
      idle_inputs();
      chk("c_wr_cwait0", {31'd0, cwait}, 32'd1);
      tick();
      chk("c_wr_we_c1", {31'd0, vramwe}, 32'd0);
      tick();
      chk("c_wr_we_c2", {31'd0, vramwe}, 32'd1);
      chk("c_wr_din", {24'd0, vramdin}, 32'hC3);
      tick();
      chk("c_wr_cack", {31'd0, cack}, 32'd1);
      chk("c_wr_cwait_end", {31'd0, cwait}, 32'd0);
      tick();

      // Simultaneous video read and CPU read of 0x0200.
      vreq = 1; vaddr = 14'h1800; creq = 1; cwe = 0; caddr = 14'h0200;
      tick();
      idle_inputs();
      tick();
      tick();
      tick();
      chk("sim_vvalid", {31'd0, vvalid}, 32'd1);
      chk("sim_c1_va", {18'd0, va}, 32'h0200);
      chk("sim_cwait", {31'd0, cwait}, 32'd1);
      tick();
      tick();
      chk("sim_cack", {31'd0, cack}, 32'd1);
      chk("sim_cdout", {24'd0, cdout}, {24'd0, ref_mem[14'h0200]});
      tick();

      // Two video requests one cycle apart: second is dropped.
      vv0 = vv_seen;
      vreq = 1; vaddr = 14'h1810;
      tick();
      vaddr = 14'h1900;
      tick();
      idle_inputs();
      for (int i = 0; i < 6; i++) tick();
      chk("ovr_flag", {31'd0, voverrun}, 32'd1);
      chk("ovr_one_vvalid", vv_seen - vv0, 32'd1);
      chk("ovr_vdata", {24'd0, vdata}, {24'd0, ref_mem[14'h1810]});

      // Reset during V2, with requests present while reset is held.
      vv0 = vv_seen;
      vreq = 1; vaddr = 14'h1800;
      tick();
      idle_inputs();
      tick();
      tick();
      rst_n = 0; vreq = 1; creq = 1; vaddr = 14'h1820;
      tick();
      chk("rst_va", {18'd0, va}, 32'd0);
      chk("rst_vdata", {24'd0, vdata}, 32'd0);
      rst_n = 1;
      idle_inputs();
      for (int i = 0; i < 4; i++) tick();
      chk("rst_no_vvalid", vv_seen - vv0, 32'd0);
      vreq = 1; vaddr = 14'h1800;
      tick();
      idle_inputs();
      tick();
      tick();
      tick();
      chk("rst_after_vvalid", {31'd0, vvalid}, 32'd1);
      chk("rst_after_vdata", {24'd0, vdata}, 32'h5A);
      tick();

      // Random traffic over a small address window to exercise read-after-write.
      ck0 = ck_seen;
      for (int i = 0; i < 600; i++) begin
         rst_n = ($urandom_range(0, 199) != 0);
         vreq  = ($urandom_range(0, 3) == 0);
         vaddr = 14'h0100 + 14'($urandom_range(0, 7));
         creq  = ($urandom_range(0, 2) == 0);
         cwe   = $urandom_range(0, 1) != 0;
         caddr = 14'h0100 + 14'($urandom_range(0, 7));
         cdin  = 8'($urandom);
         tick();
      end
      rst_n = 1;
      idle_inputs();
      for (int i = 0; i < 8; i++) tick();
      chk("rand_cpu_progress", {31'd0, (ck_seen - ck0) > 20}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 The port list SHALL be as follows, clock and reset first; one clock, reset synchronous and active-low:
  clk14       in   1   14 MHz master clock; all state updates on rising edge
  rst_n       in   1   synchronous active-low reset
  vreq        in   1   video fetch request, single-cycle pulse
  vaddr       in   14  video fetch address, valid with vreq
  vdata       out  8   video fetch data
  vvalid      out  1   vdata valid, one-cycle pulse
  creq        in   1   CPU access request, single-cycle pulse
  cwe         in   1   CPU access is write (1) / read (0), valid with creq
  caddr       in   14  CPU address, valid with creq
  cdin        in   8   CPU write data, valid with creq
  cdout       out  8   CPU read data
  cack        out  1   CPU access complete, one-cycle pulse
  cwait       out  1   CPU request pending or in flight
  voverrun    out  1   sticky: vreq arrived while a video request was pending
  va          out  14  VRAM address
  vramdin     out  8   VRAM write data
  vramdout    in   8   VRAM read data
  vramcs      out  1   VRAM chip select, active high
  vramoe      out  1   VRAM output enable, active high
  vramwe      out  1   VRAM write enable, active high

Function
REQ-002 Each requester SHALL have a pending flag plus captured address/data/cwe, loaded on its req pulse and cleared on grant.
REQ-003 A req pulse arriving while the same requester is pending SHALL be dropped; the video case SHALL set voverrun.
REQ-004 The FSM SHALL have states IDLE, V1, V2, C1, C2.
REQ-005 Grant SHALL be evaluated in IDLE, V2 and C2, from pending flags only: video pending -> V1; else CPU pending -> C1; else IDLE.
REQ-006 Video SHALL have fixed priority; on simultaneous pending, video is granted and the CPU waits.
REQ-007 V1->V2 and C1->C2 SHALL be unconditional, so each access occupies exactly 2 cycles and back-to-back throughput is one access per 2 cycles.
REQ-008 In V1/V2: va=captured vaddr, vramcs=1, vramoe=1, vramwe=0.
REQ-009 In C1/C2: va=captured caddr, vramcs=1, and vramdin=captured cdin.
REQ-010 For a CPU read, vramoe=1 in C1 and C2; for a CPU write, vramwe=1 in C2 only and vramoe=0 throughout.
REQ-011 In IDLE: vramcs=vramoe=vramwe=0, and va and vramdin hold their last values.
REQ-012 On leaving V2, vdata SHALL latch vramdout and vvalid SHALL pulse in the next cycle.
REQ-013 On leaving C2, cdout SHALL latch vramdout for reads (unchanged for writes) and cack SHALL pulse in the next cycle.
REQ-014 Latency from idle: vreq high at edge k -> vvalid high in the cycle after edge k+3; creq likewise gives cack.
REQ-015 cwait SHALL be high from the edge after creq until the edge at which cack asserts.
REQ-016 A CPU access in C1/C2 SHALL complete even if vreq arrives; video is granted at the C2 decision point.
REQ-017 vdata and cdout SHALL hold between pulses.

Reset
REQ-018 While rst_n=0 at an edge: FSM=IDLE; pending flags, vvalid, cack, cwait, voverrun, vramcs, vramoe, vramwe=0; va, vramdin, vdata, cdout=0.
REQ-019 Reset mid-access SHALL abort the access with no vvalid/cack pulse afterwards, and requests present during reset SHALL be ignored.

Structure
REQ-020 Package zx_mem_pkg SHALL hold the FSM state encoding, the VRAM address width (14) and the data width (8).
REQ-021 One sub-module, arb_req_latch (pending flag plus capture register plus overrun detect), SHALL be instantiated once per requester.

Verification
REQ-022 Single video read: vreq, vaddr=0x1800, vramdout model=0x5A -> vramcs/vramoe high for 2 cycles with va=0x1800; vvalid at k+3 with vdata=0x5A.
REQ-023 CPU write: creq, cwe=1, caddr=0x0100, cdin=0xC3 -> vramwe high 1 cycle (C2) with vramdin=0xC3; cack at k+3; cwait high for 3 cycles.
REQ-024 Simultaneous vreq and creq (read of 0x0200) -> video served first; CPU in C1 two cycles later; cack at k+5; cwait held throughout.
REQ-025 vreq twice, 1 cycle apart -> second pulse dropped, voverrun=1, only one vvalid.
REQ-026 rst_n low during V2 -> no vvalid; all outputs 0 on the next edge; FSM returns to IDLE and a subsequent vreq completes with normal k+3 latency.
